// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: I/O window placement and the RAM wait-state FSM encoding.
package mips_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_FFE0;
    localparam int unsigned IO_WINDOW_WORDS = 16;
    localparam int unsigned IO_IDX_W        = 4;
    localparam int unsigned WAIT_CNT_W      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

endpackage

// File: rtl/mmio_wait_fsm.sv
// RAM wait-state sequencer: holds the core in stall for RAM_WAIT cycles, then flags completion.
module mmio_wait_fsm
    import mips_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic stall,
    output logic done
);

    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (RAM_WAIT > 0) ? WAIT_CNT_W'(RAM_WAIT - 1) : '0;

    wait_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    stall_raw;
    logic                    done_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A request that disappears mid-wait abandons the access without completing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        done_raw  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (RAM_WAIT == 0) begin
                        done_raw = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        cnt_d     = CNT_INIT;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    done_raw = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset drops stall immediately, not just at the next edge.
    assign stall = stall_raw & ~rst;
    assign done  = done_raw & ~rst;

endmodule

// File: rtl/mmio_controller.sv
// Memory-stage MMIO/data-RAM controller: decodes the I/O window, owns the port registers
// and the registered read-data path, and stalls the core during RAM wait states.
module mmio_controller
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned NUM_OUT  = 1,
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    output logic [WIDTH-1:0]         rdata,
    output logic                     stall,
    output logic                     ram_rd_en,
    output logic                     ram_wr_en,
    input  logic [WIDTH-1:0]         ram_rdata,
    input  logic [NUM_IN*WIDTH-1:0]  in_port,
    output logic [NUM_OUT*WIDTH-1:0] out_port
);

    logic [NUM_IN-1:0][WIDTH-1:0]  in_q;
    logic [NUM_OUT-1:0][WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0]              rdata_q, rdata_d;
    logic [WIDTH-1:0]              io_rdata;

    logic [31:0]         offset;
    logic                in_window;
    logic [IO_IDX_W-1:0] word_idx;
    logic                rd_req;
    logic                wr_req;
    logic                ram_req;
    logic                ram_done;

    // Address decode; a full-width compare keeps wrap-around below IO_BASE out of the window.
    assign offset    = addr - IO_BASE;
    assign in_window = offset < 32'(IO_WINDOW_WORDS * 4);
    assign word_idx  = offset[IO_IDX_W+1:2];

    // Read wins when both strobes are high.
    assign rd_req  = MemRead;
    assign wr_req  = MemWrite & ~MemRead;
    assign ram_req = (rd_req | wr_req) & ~in_window;

    mmio_wait_fsm #(
        .RAM_WAIT (RAM_WAIT)
    ) u_wait_fsm (
        .clk   (clk),
        .rst   (rst),
        .req   (ram_req),
        .stall (stall),
        .done  (ram_done)
    );

    assign ram_rd_en = rd_req & ~in_window & ~rst;
    assign ram_wr_en = wr_req & ~in_window & ~rst;

    // I/O read mux: input ports first, then output-port readback; gaps read as zero.
    always_comb begin
        io_rdata = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (word_idx == IO_IDX_W'(i)) begin
                io_rdata = in_q[i];
            end
        end
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (word_idx == IO_IDX_W'(NUM_IN + j)) begin
                io_rdata = out_q[j];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        out_d   = out_q;
        if (rd_req && in_window) begin
            rdata_d = io_rdata;
        end else if (rd_req && !in_window && ram_done) begin
            rdata_d = ram_rdata;
        end
        if (wr_req && in_window) begin
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                if (word_idx == IO_IDX_W'(NUM_IN + j)) begin
                    out_d[j] = wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            out_q   <= '0;
            in_q    <= '0;
        end else begin
            rdata_q <= rdata_d;
            out_q   <= out_d;
            in_q    <= in_port;
        end
    end

    assign rdata    = rdata_q;
    assign out_port = out_q;

endmodule
